// File: rtl/fb_write_queue.sv
// Processor-store to VGA index-RAM write queue.
// Window-filters stores, buffers them, and drains them on display grants. Also runs a full-screen clear sweep.
module fb_write_queue #(
    parameter logic [31:0] FB_BASE  = 32'h0000_1000,
    parameter int unsigned FB_WORDS = 307200,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iWR_EN,
    input  logic [31:0]       iWR_ADDR,
    input  logic [31:0]       iWR_DATA,
    input  logic              iDRAIN_OK,
    input  logic              iCLR_REQ,
    input  logic [DATA_W-1:0] iCLR_COLOR,
    input  logic              iCLR_OVF,
    output logic              oPIX_WE,
    output logic [ADDR_W-1:0] oPIX_ADDR,
    output logic [DATA_W-1:0] oPIX_DATA,
    output logic [CNT_W-1:0]  oCOUNT,
    output logic              oFULL,
    output logic              oEMPTY,
    output logic              oBUSY,
    output logic              oOVERFLOW,
    output logic [15:0]       oDROP_CNT
);

    localparam int unsigned       PTR_W    = CNT_W - 1;
    localparam logic [31:0]       FB_END   = FB_BASE + FB_WORDS;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_WORDS - 1);

    typedef enum logic {S_RUN, S_CLEAR} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              pix_we_q, pix_we_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic [15:0]       drop_cnt_q;

    entry_t            mem_q [DEPTH];

    logic [31:0] offset;
    logic        in_window;
    logic        push_req;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_ok;
    logic        drop;
    entry_t      wr_entry;
    entry_t      rd_entry;

    assign offset    = iWR_ADDR - FB_BASE;
    assign in_window = (iWR_ADDR >= FB_BASE) && (iWR_ADDR < FB_END);
    assign push_req  = iWR_EN && in_window;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = (state_q == S_RUN) && iDRAIN_OK && !empty;
    // A full FIFO still accepts a store when the same edge frees a slot.
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign wr_entry  = '{addr: offset[ADDR_W-1:0], data: iWR_DATA[DATA_W-1:0]};
    assign rd_entry  = mem_q[rd_ptr_q];

    logic unused_bits;
    assign unused_bits = ^{iWR_DATA[31:DATA_W], offset[31:ADDR_W]};

    // NOTE: the storage array carries no reset; pointers and count alone define validity.
    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
            if (iCLR_OVF) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        color_d    = color_q;
        pix_we_d   = 1'b0;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;
        unique case (state_q)
            S_RUN: begin
                if (pop) begin
                    pix_we_d   = 1'b1;
                    pix_addr_d = rd_entry.addr;
                    pix_data_d = rd_entry.data;
                end
                if (iCLR_REQ) begin
                    state_d = S_CLEAR;
                    color_d = iCLR_COLOR;
                    sweep_d = '0;
                end
            end
            S_CLEAR: begin
                if (iDRAIN_OK) begin
                    pix_we_d   = 1'b1;
                    pix_addr_d = sweep_q;
                    pix_data_d = color_q;
                    if (sweep_q == LAST_PIX) begin
                        state_d = S_RUN;
                    end else begin
                        sweep_d = sweep_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= S_RUN;
            sweep_q    <= '0;
            color_q    <= '0;
            pix_we_q   <= 1'b0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            color_q    <= color_d;
            pix_we_q   <= pix_we_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
        end
    end

    assign oPIX_WE   = pix_we_q;
    assign oPIX_ADDR = pix_addr_q;
    assign oPIX_DATA = pix_data_q;
    assign oCOUNT    = count_q;
    assign oFULL     = full;
    assign oEMPTY    = empty;
    assign oBUSY     = (state_q == S_CLEAR);
    assign oOVERFLOW = overflow_q;
    assign oDROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_fb_write_queue.sv
// Bench for fb_write_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_fb_write_queue;

    localparam logic [31:0] FB_BASE  = 32'h0000_1000;
    localparam int unsigned TB_WORDS = 1024;
    localparam logic [31:0] FB_SPAN  = 32'(TB_WORDS);
    localparam int          DEPTH    = 16;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        drain_ok;
    logic        clr_req;
    logic [7:0]  clr_color;
    logic        clr_ovf;

    logic        pix_we;
    logic [18:0] pix_addr;
    logic [7:0]  pix_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    fb_write_queue #(
        .FB_BASE (FB_BASE),
        .FB_WORDS(TB_WORDS)
    ) dut (
        .iCLK      (clk),
        .iRST_n    (rst_n),
        .iWR_EN    (wr_en),
        .iWR_ADDR  (wr_addr),
        .iWR_DATA  (wr_data),
        .iDRAIN_OK (drain_ok),
        .iCLR_REQ  (clr_req),
        .iCLR_COLOR(clr_color),
        .iCLR_OVF  (clr_ovf),
        .oPIX_WE   (pix_we),
        .oPIX_ADDR (pix_addr),
        .oPIX_DATA (pix_data),
        .oCOUNT    (count),
        .oFULL     (full),
        .oEMPTY    (empty),
        .oBUSY     (busy),
        .oOVERFLOW (overflow),
        .oDROP_CNT (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending pixels plus clear-sweep bookkeeping.
    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } pix_t;

    pix_t        m_q[$];
    bit          m_busy;
    int          m_sweep;
    logic [7:0]  m_color;
    bit          m_we;
    logic [18:0] m_addr;
    logic [7:0]  m_data;
    bit          m_ovf;
    int          m_drop;

    always @(posedge clk) begin
        bit   grant;
        bit   push;
        pix_t e;
        if (!rst_n) begin
            m_q.delete();
            m_busy  = 0;
            m_sweep = 0;
            m_color = '0;
            m_we    = 0;
            m_addr  = '0;
            m_data  = '0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            grant = drain_ok;
            push  = wr_en && (wr_addr >= FB_BASE) && (wr_addr < FB_BASE + FB_SPAN);
            m_we  = 0;
            if (m_busy) begin
                if (grant) begin
                    m_we   = 1;
                    m_addr = 19'(m_sweep);
                    m_data = m_color;
                    if (m_sweep == int'(TB_WORDS) - 1) m_busy = 0;
                    else m_sweep++;
                end
            end else begin
                if (grant && m_q.size() != 0) begin
                    e      = m_q.pop_front();
                    m_we   = 1;
                    m_addr = e.a;
                    m_data = e.d;
                end
                if (clr_req) begin
                    m_busy  = 1;
                    m_sweep = 0;
                    m_color = clr_color;
                end
            end
            if (push && m_q.size() < DEPTH) begin
                e.a = 19'(wr_addr - FB_BASE);
                e.d = wr_data[7:0];
                m_q.push_back(e);
                push = 0;
            end
            if (clr_ovf) begin
                m_ovf  = 0;
                m_drop = 0;
            end else if (push) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        #1;
        check("cycle{we,addr,data,count,full,empty,busy,ovf,drops}",
              {11'b0, pix_we, pix_addr, pix_data, count, full, empty, busy, overflow, drop_cnt},
              {11'b0, m_we, m_addr, m_data, 5'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0,
               m_busy, m_ovf, 16'(m_drop)});
    end

    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic drain, input logic clr, input logic [7:0] col, input logic ovf);
        @(negedge clk);
        wr_en     = we;
        wr_addr   = addr;
        wr_data   = data;
        drain_ok  = drain;
        clr_req   = clr;
        clr_color = col;
        clr_ovf   = ovf;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic drain);
        step(1'b0, 32'h0, 32'h0, drain, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " we"},    64'(pix_we),   64'h0);
        check({tag, " addr"},  64'(pix_addr), 64'h0);
        check({tag, " data"},  64'(pix_data), 64'h0);
        check({tag, " count"}, 64'(count),    64'h0);
        check({tag, " full"},  64'(full),     64'h0);
        check({tag, " empty"}, 64'(empty),    64'h1);
        check({tag, " busy"},  64'(busy),     64'h0);
        check({tag, " ovf"},   64'(overflow), 64'h0);
        check({tag, " drops"}, 64'(drop_cnt), 64'h0);
    endtask

    initial begin
        int n;
        bit hit;
        logic [31:0] a;
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        drain_ok  = 1'b0;
        clr_req   = 1'b0;
        clr_color = '0;
        clr_ovf   = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // T1: single store, minimum latency
        step(1'b1, 32'h1005, 32'h0000_003A, 1'b1, 1'b0, 8'h00, 1'b0);
        check("t1 count after push", 64'(count), 64'd1);
        check("t1 no strobe yet", 64'(pix_we), 64'd0);
        idle(1'b1);
        check("t1 strobe", 64'(pix_we), 64'd1);
        check("t1 addr", 64'(pix_addr), 64'd5);
        check("t1 data", 64'(pix_data), 64'h3A);
        idle(1'b1);
        check("t1 strobe one cycle", 64'(pix_we), 64'd0);
        check("t1 addr holds", 64'(pix_addr), 64'd5);

        // T2: window boundaries just outside
        step(1'b1, 32'h0000_0FFF, 32'h11, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, FB_BASE + FB_SPAN, 32'h22, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t2 count", 64'(count), 64'd0);
        check("t2 drops", 64'(drop_cnt), 64'd0);

        // T3: overfill with drain blocked
        for (int i = 0; i < 18; i++) step(1'b1, FB_BASE + 32'(i), 32'(8'h10 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        check("t3 full", 64'(full), 64'd1);
        check("t3 count", 64'(count), 64'd16);
        check("t3 ovf", 64'(overflow), 64'd1);
        check("t3 drops", 64'(drop_cnt), 64'd2);

        // T4: full FIFO, simultaneous store and grant
        step(1'b1, FB_BASE + 32'h100, 32'hAA, 1'b1, 1'b0, 8'h00, 1'b0);
        check("t4 count", 64'(count), 64'd16);
        check("t4 drops", 64'(drop_cnt), 64'd2);
        check("t4 first out addr", 64'(pix_addr), 64'd0);
        check("t4 first out data", 64'(pix_data), 64'h10);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("t4 drops cleared", 64'(drop_cnt), 64'd0);
        repeat (18) idle(1'b1);
        check("t3 drained", 64'(empty), 64'd1);

        // T5: full clear sweep with a store queued mid-sweep
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h07, 1'b0);
        check("t5 busy", 64'(busy), 64'd1);
        n   = 0;
        hit = 0;
        for (int i = 0; i < int'(TB_WORDS) + 10; i++) begin
            if (i == 5) step(1'b1, FB_BASE + 32'h123, 32'h55, 1'b1, 1'b0, 8'h00, 1'b0);
            else if (i == 100) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h3C, 1'b0);
            else idle(1'b1);
            if (pix_we) n++;
            if (!busy) begin
                hit = 1;
                break;
            end
        end
        check("t5 sweep finished", 64'(hit), 64'd1);
        check("t5 strobe count", 64'(n), 64'(TB_WORDS));
        check("t5 last addr", 64'(pix_addr), 64'(TB_WORDS - 1));
        idle(1'b1);
        check("t5 queued store addr", 64'(pix_addr), 64'h123);
        check("t5 queued store data", 64'(pix_data), 64'h55);

        // T6: reset mid-sweep with stores pending
        for (int i = 0; i < 3; i++) step(1'b1, FB_BASE + 32'(40 + i), 32'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h99, 1'b0);
        hit = 0;
        for (int i = 0; i < int'(TB_WORDS) + 10; i++) begin
            idle(1'b1);
            if (pix_we && pix_addr == 19'd1000) begin
                hit = 1;
                break;
            end
        end
        check("t6 reached sweep 1000", 64'(hit), 64'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_reset_values("t6 async reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1'b1);
            if (pix_we) n++;
        end
        check("t6 strobes after release", 64'(n), 64'd0);

        // T7: drop counter saturation, then clear with a same-cycle drop
        for (int i = 0; i < DEPTH; i++) step(1'b1, FB_BASE + 32'(i), 32'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, FB_BASE + 32'h200, 32'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t7 drops saturated", 64'(drop_cnt), 64'hFFFF);
        check("t7 ovf", 64'(overflow), 64'd1);
        step(1'b1, FB_BASE + 32'h200, 32'h5A, 1'b0, 1'b0, 8'h00, 1'b1);
        check("t7 clear beats drop cnt", 64'(drop_cnt), 64'd0);
        check("t7 clear beats drop ovf", 64'(overflow), 64'd0);
        step(1'b1, FB_BASE + 32'h200, 32'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t7 counts again", 64'(drop_cnt), 64'd1);
        repeat (20) idle(1'b1);

        // Randomized phase
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 7))
                0: a = FB_BASE - 32'd1;
                1: a = FB_BASE + FB_SPAN;
                2: a = FB_BASE + FB_SPAN - 32'd1;
                3: a = $urandom;
                default: a = FB_BASE + 32'($urandom_range(0, TB_WORDS - 1));
            endcase
            step(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 999) == 0), 8'($urandom), ($urandom_range(0, 49) == 0));
        end
        hit = 0;
        for (int i = 0; i < 2 * int'(TB_WORDS) + 40; i++) begin
            idle(1'b1);
            if (!busy && empty) begin
                hit = 1;
                break;
            end
        end
        check("random phase drains", 64'(hit), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
